be_redirect_unit: RTL
=====================

Name: be_redirect_unit

Overview:
- Back-end to front-end redirect generator; the be→fe return path of the fetch/decode queue interface.
- Collects branch resolutions from execute, keeps the oldest outstanding mispredict by ROB age, and waits for that branch to reach commit.
- At commit it pulses be_fe_mispredict_o with the corrected PC, which steers fetch and clears the fe→be FIFO. It then holds a back-end flush for a fixed drain window.

Parameters:
word_width_p, 16, PC / target width (WORD_SIZE_P)
rob_tag_width_p, 5, ROB index width (32-entry ROB, wrap-around tags)
drain_cycles_p, 2, cycles flush_o stays high after the redirect cycle (≥1)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
br_v_i  in  1  branch resolution valid (one per cycle max)
br_tag_i  in  rob_tag_width_p  ROB tag of resolving branch
br_mispredict_i  in  1  resolution was mispredicted
br_target_i  in  word_width_p  correct next PC
rob_head_i  in  rob_tag_width_p  current oldest ROB tag (age base)
commit_v_i  in  1  ROB retiring head this cycle
commit_tag_i  in  rob_tag_width_p  tag being retired (== rob_head_i)
be_fe_mispredict_o  out  1  one-cycle redirect pulse to FE and FIFO reset
be_fe_redirected_pc_o  out  word_width_p  redirect target
flush_o  out  1  back-end squash (ROB/RS/rename)
pending_o  out  1  a mispredict is captured and awaiting commit

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, pending tag/target 0. Reset mid-DRAIN aborts the drain immediately.
- All outputs are registered. There is no combinational path from any input to any output.
- Age: age(t) = (t − rob_head_i) mod 2^rob_tag_width_p, unsigned. A smaller age is older.
- States:
  - IDLE: on br_v_i&br_mispredict_i, capture tag/target → PENDING. Correct-predicted resolutions are ignored.
  - PENDING: on a new mispredict with age(br_tag_i) < age(pend_tag), replace tag and target. Equal or younger is ignored. On commit_v_i && commit_tag_i==pend_tag → REDIRECT. Commit wins over a same-cycle younger resolution, which is dropped.
  - REDIRECT (exactly 1 cycle): be_fe_mispredict_o=1, be_fe_redirected_pc_o=pend_target, flush_o=1 → DRAIN with counter=drain_cycles_p.
  - DRAIN: flush_o=1, counter decrements each cycle, and at counter==1 → IDLE next cycle. All br_v_i are ignored (squashed work).
- Latency: the redirect pulse appears the cycle after the matching commit is sampled. flush_o is high for 1+drain_cycles_p consecutive cycles.
- be_fe_redirected_pc_o holds its last value after the pulse. It is valid only when the pulse is high.
- pending_o is high exactly in PENDING.
- Tag wrap: the age compare must be correct when tags straddle 31→0 relative to rob_head_i.
- Preconditions (assertions in the bench, not handled in RTL):
  - A tag commits only after its resolution cycle.
  - commit_tag_i == rob_head_i whenever commit_v_i is high.
- Non-matching commits in PENDING are ignored.

Test Plan:
- Basic redirect: reset, head=3; mispredict tag=5, target=0x0120 at cycle 10; commit tag=5 at cycle 14 → pulse at cycle 15 with pc=0x0120; flush_o high cycles 15-17 (drain=2); IDLE at 18.
- Older replaces: head=0; mispredict tag=8 (0x0200), then tag=4 (0x0100) → commit 4 fires pc=0x0100; the tag-8 redirect never fires.
- Wrap-around: head=30; mispredict tag=2 (age 4), then tag=31 (age 1) → tag 31 is kept, and its commit redirects to the tag-31 target. Then repeat with the order swapped and check the same result.
- Squash in DRAIN / younger ignored:
  - Mispredict arriving during REDIRECT/DRAIN → no capture; pending_o stays 0 after IDLE.
  - A younger mispredict in PENDING does not change the target.
- Simultaneous: commit of pend_tag plus a same-cycle younger mispredict → single pulse with the original target; no second pulse.
- Async reset: assert reset_i mid-DRAIN (between clock edges) → flush_o and pending_o drop immediately. After release, a new mispredict/commit sequence works normally.

Source files
------------

// File: rtl/be_redirect_unit.sv
// Back-end redirect generator: tracks the oldest outstanding mispredict by ROB age,
// fires a one-cycle redirect when that branch commits, then holds a back-end flush.
module be_redirect_unit #(
  parameter int word_width_p    = 16,
  parameter int rob_tag_width_p = 5,
  parameter int drain_cycles_p  = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       br_v_i,
  input  logic [rob_tag_width_p-1:0] br_tag_i,
  input  logic                       br_mispredict_i,
  input  logic [word_width_p-1:0]    br_target_i,
  input  logic [rob_tag_width_p-1:0] rob_head_i,
  input  logic                       commit_v_i,
  input  logic [rob_tag_width_p-1:0] commit_tag_i,
  output logic                       be_fe_mispredict_o,
  output logic [word_width_p-1:0]    be_fe_redirected_pc_o,
  output logic                       flush_o,
  output logic                       pending_o
);

  localparam int cnt_width_lp = $clog2(drain_cycles_p + 1);

  localparam logic [1:0] state_idle     = 2'd0;
  localparam logic [1:0] state_pending  = 2'd1;
  localparam logic [1:0] state_redirect = 2'd2;
  localparam logic [1:0] state_drain    = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [rob_tag_width_p-1:0] pend_tag_q, pend_tag_d;
  logic [word_width_p-1:0]    pend_target_q, pend_target_d;
  logic [cnt_width_lp-1:0]    cnt_q, cnt_d;
  logic                       mispredict_q, mispredict_d;
  logic [word_width_p-1:0]    pc_q, pc_d;
  logic                       flush_q, flush_d;
  logic                       pending_q, pending_d;

  // Ages are distances from the ROB head; modular subtraction handles tag wrap.
  logic [rob_tag_width_p-1:0] br_age, pend_age;
  logic                       br_mis;

  always_comb begin
    br_age        = br_tag_i - rob_head_i;
    pend_age      = pend_tag_q - rob_head_i;
    br_mis        = br_v_i & br_mispredict_i;
    state_d       = state_q;
    pend_tag_d    = pend_tag_q;
    pend_target_d = pend_target_q;
    cnt_d         = cnt_q;

    case (state_q)
      state_idle: begin
        if (br_mis) begin
          pend_tag_d    = br_tag_i;
          pend_target_d = br_target_i;
          state_d       = state_pending;
        end
      end
      state_pending: begin
        // A matching commit takes priority; any same-cycle resolution is younger and dropped.
        if (commit_v_i && (commit_tag_i == pend_tag_q)) begin
          state_d = state_redirect;
        end else if (br_mis && (br_age < pend_age)) begin
          pend_tag_d    = br_tag_i;
          pend_target_d = br_target_i;
        end
      end
      state_redirect: begin
        cnt_d   = cnt_width_lp'(drain_cycles_p);
        state_d = state_drain;
      end
      default: begin
        cnt_d = cnt_q - cnt_width_lp'(1);
        if (cnt_q == cnt_width_lp'(1)) begin
          state_d = state_idle;
        end
      end
    endcase

    // Outputs are registered copies of the next-state decode.
    mispredict_d = (state_d == state_redirect);
    flush_d      = (state_d == state_redirect) || (state_d == state_drain);
    pending_d    = (state_d == state_pending);
    pc_d         = (state_d == state_redirect) ? pend_target_q : pc_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= state_idle;
      pend_tag_q    <= '0;
      pend_target_q <= '0;
      cnt_q         <= '0;
      mispredict_q  <= 1'b0;
      pc_q          <= '0;
      flush_q       <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_tag_q    <= pend_tag_d;
      pend_target_q <= pend_target_d;
      cnt_q         <= cnt_d;
      mispredict_q  <= mispredict_d;
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      pending_q     <= pending_d;
    end
  end

  assign be_fe_mispredict_o    = mispredict_q;
  assign be_fe_redirected_pc_o = pc_q;
  assign flush_o               = flush_q;
  assign pending_o             = pending_q;

endmodule
